// File: rtl/mul_sequencer_if.sv
// Handshake and shared-adder bus between the operand/control side, the Add unit
// and the mul_sequencer multiplier controller.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic               START;
  logic [WIDTH-1:0]   DATA1;
  logic [WIDTH-1:0]   DATA2;
  logic [WIDTH-1:0]   ADD_A;
  logic [WIDTH-1:0]   ADD_B;
  logic [WIDTH-1:0]   ADD_RESULT;
  logic               ADD_REQ;
  logic               BUSY;
  logic               DONE;
  logic [2*WIDTH-1:0] PRODUCT;

  // Requester / ALU side: issues operands, owns the Add unit result.
  modport master (
    output START, DATA1, DATA2, ADD_RESULT,
    input  ADD_A, ADD_B, ADD_REQ, BUSY, DONE, PRODUCT
  );

  // The multiplier controller itself.
  modport slave (
    input  START, DATA1, DATA2, ADD_RESULT,
    output ADD_A, ADD_B, ADD_REQ, BUSY, DONE, PRODUCT
  );
endinterface

// File: rtl/mul_sequencer.sv
// Unsigned WIDTH x WIDTH shift-add multiplier that borrows the ALU's shared
// Add unit for WIDTH iterations and produces a 2*WIDTH-bit product.
module mul_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [WIDTH-1:0]     p_hi, p_hi_n;
  logic [WIDTH-1:0]     p_lo, p_lo_n;
  logic [WIDTH-1:0]     m, m_n;
  logic [2*WIDTH-1:0]   product, product_n;

  logic [WIDTH-1:0]     add_a, add_b;
  logic                 add_req, busy, done, carry;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      m       <= '0;
      product <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      p_hi    <= p_hi_n;
      p_lo    <= p_lo_n;
      m       <= m_n;
      product <= product_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    p_hi_n    = p_hi;
    p_lo_n    = p_lo;
    m_n       = m;
    product_n = product;
    add_a     = '0;
    add_b     = '0;
    add_req   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    carry     = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.START) begin
          m_n     = bus.DATA1;
          p_lo_n  = bus.DATA2;
          p_hi_n  = '0;
          cnt_n   = '0;
          state_n = S_CALC;
        end
      end

      S_CALC: begin
        add_req = 1'b1;
        add_a   = p_hi;
        add_b   = m;
        // The Add unit has no carry-out, so recover it from the operand and sum MSBs.
        carry = (p_hi[WIDTH-1] & m[WIDTH-1]) |
                ((p_hi[WIDTH-1] | m[WIDTH-1]) & ~bus.ADD_RESULT[WIDTH-1]);
        if (p_lo[0]) begin
          {p_hi_n, p_lo_n} = {carry, bus.ADD_RESULT, p_lo[WIDTH-1:1]};
        end else begin
          {p_hi_n, p_lo_n} = {1'b0, p_hi, p_lo[WIDTH-1:1]};
        end
        if (cnt == CNT_W'(WIDTH - 1)) begin
          product_n = {p_hi_n, p_lo_n};
          state_n   = S_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.ADD_A   = add_a;
  assign bus.ADD_B   = add_b;
  assign bus.ADD_REQ = add_req;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.PRODUCT = product;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed and random operand pairs checked against
// plain multiplication and the IDLE/CALC/DONE timing rules.
module tb_mul_sequencer;

  logic CLK;
  logic RESET_N;

  mul_sequencer_if #(.WIDTH(8)) bus ();

  // Shared Add unit: combinational sum modulo 256.
  assign bus.ADD_RESULT = bus.ADD_A + bus.ADD_B;

  mul_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_prod = '0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for DONE; n counts falling edges since the accepting edge.
  task automatic wait_done(input logic [15:0] prev, output int unsigned n);
    n = 1;
    while (n < 12 && bus.DONE !== 1'b1) begin
      check("prod_stable_in_calc", bus.PRODUCT, prev);
      check("req_in_calc", bus.ADD_REQ, 1);
      check("busy_in_calc", bus.BUSY, 1);
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int unsigned n;
    logic [15:0] prev;
    logic [15:0] exp;
    exp  = 16'(a) * 16'(b);
    prev = exp_prod;
    @(negedge CLK);
    bus.START = 1'b1;
    bus.DATA1 = a;
    bus.DATA2 = b;
    @(negedge CLK);
    if (!hold) bus.START = 1'b0;
    bus.DATA1 = 8'($urandom);
    bus.DATA2 = 8'($urandom);
    check("first_calc_add_a", bus.ADD_A, 0);
    check("first_calc_add_b", bus.ADD_B, a);
    wait_done(prev, n);
    check("done_latency", n, 9);
    exp_prod = exp;
    check("product", bus.PRODUCT, exp);
    check("done_busy", bus.BUSY, 1);
    check("done_req", bus.ADD_REQ, 0);
    check("done_add_b", bus.ADD_B, 0);
    @(negedge CLK);
    check("done_width", bus.DONE, 0);
    check("idle_busy", bus.BUSY, 0);
    check("idle_add_a", bus.ADD_A, 0);
    check("product_held", bus.PRODUCT, exp);
  endtask

  initial begin
    int unsigned n;
    logic [7:0] ra, rb;

    RESET_N   = 1'b0;
    bus.START = 1'b0;
    bus.DATA1 = '0;
    bus.DATA2 = '0;
    #12;
    check("rst_product", bus.PRODUCT, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_req", bus.ADD_REQ, 0);
    check("rst_add_a", bus.ADD_A, 0);
    check("rst_add_b", bus.ADD_B, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    run_op(8'd25, 8'd3, 1'b0);

    // Asynchronous reset while CLK is high, away from any edge.
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    exp_prod = '0;
    check("async_rst_product", bus.PRODUCT, 0);
    check("async_rst_busy", bus.BUSY, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    run_op(8'd25,  8'd3,   1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd16,  8'd16,  1'b0);
    run_op(8'd200, 8'd200, 1'b0);
    run_op(8'd0,   8'd173, 1'b0);
    run_op(8'd173, 8'd0,   1'b0);

    // START held high: the following operation begins only at the IDLE edge after DONE.
    run_op(8'd91, 8'd37, 1'b1);
    bus.DATA1 = 8'd13;
    bus.DATA2 = 8'd11;
    @(negedge CLK);
    check("held_start_accept", bus.BUSY, 1);
    check("held_start_add_b", bus.ADD_B, 13);
    bus.START = 1'b0;
    wait_done(exp_prod, n);
    check("held_second_latency", n, 9);
    exp_prod = 16'd143;
    check("held_second_product", bus.PRODUCT, exp_prod);
    @(negedge CLK);

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 1'b0);
    end

    // Reset during CALC iteration 4 aborts without DONE.
    @(negedge CLK);
    bus.START = 1'b1;
    bus.DATA1 = 8'd7;
    bus.DATA2 = 8'd9;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (4) @(negedge CLK);
    check("midop_still_busy", bus.BUSY, 1);
    RESET_N = 1'b0;
    #1;
    exp_prod = '0;
    check("midop_rst_busy", bus.BUSY, 0);
    check("midop_rst_product", bus.PRODUCT, 0);
    check("midop_rst_req", bus.ADD_REQ, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("midop_no_done", bus.DONE, 0);
      check("midop_idle", bus.BUSY, 0);
    end
    run_op(8'd7, 8'd9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle unsigned 8x8 multiplier controller for the ALU.
- Adds no adder of its own. It time-shares the existing 8-bit combinational Add unit, driving its two operands and reading back the sum for 8 shift-add iterations.
- Produces a 16-bit product; the processor's MUL path takes the low byte, and the high byte is available for overflow detection.
- Sits beside the ALU, between the operand registers and the ALU result mux.

Parameters:
- WIDTH, 8, operand width; the counter and product widths derive from it (product = 2*WIDTH).
- CNT_W, 3, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- DATA1  input  WIDTH  multiplicand, unsigned; captured when START is accepted.
- DATA2  input  WIDTH  multiplier, unsigned; captured when START is accepted.
- ADD_A  output  WIDTH  operand 1 to the shared Add unit.
- ADD_B  output  WIDTH  operand 2 to the shared Add unit.
- ADD_RESULT  input  WIDTH  sum from the Add unit (combinational, ADD_A+ADD_B mod 2**WIDTH).
- ADD_REQ  output  1  high while this block needs the adder (CALC state).
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle completion pulse.
- PRODUCT  output  2*WIDTH  result; held stable until the next accepted START.

Behaviour:
- Async reset (RESET_N=0), effective immediately regardless of clock:
  - state=IDLE, counter=0, internal P_HI/P_LO/M registers=0.
  - PRODUCT=0, BUSY=0, DONE=0, ADD_REQ=0, ADD_A=0, ADD_B=0.
- Reset mid-operation aborts the operation: no DONE pulse, PRODUCT=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - At an edge with START=1: M<=DATA1, P_LO<=DATA2, P_HI<=0, counter<=0, go to CALC.
  - START=0: stay in IDLE.
- CALC (exactly WIDTH cycles, counter 0..WIDTH-1):
  - ADD_REQ=1, ADD_A=P_HI, ADD_B=M.
  - If P_LO[0]=1: carry = (A[msb]&B[msb]) | ((A[msb]|B[msb]) & ~ADD_RESULT[msb]).
    - {P_HI,P_LO} <= {carry, ADD_RESULT, P_LO[WIDTH-1:1]}, i.e. the (2*WIDTH+1)-bit value {carry,sum,P_LO} shifted right by 1.
  - If P_LO[0]=0: {P_HI,P_LO} <= {1'b0, P_HI, P_LO[WIDTH-1:1]}.
    - ADD_A/ADD_B are still driven, but ADD_RESULT is ignored.
  - At counter==WIDTH-1: PRODUCT<={next P_HI, next P_LO}, go to DONE. Otherwise counter+1.
- DONE: DONE=1 for exactly one cycle, BUSY=1, ADD_REQ=0; next edge goes to IDLE.
- Outside CALC: ADD_REQ=0 and ADD_A=ADD_B=0, so the ALU mux can give the adder to the normal datapath.
- Latency: START sampled at edge E0; CALC spans E1..E8; DONE is high between E8 and E9. Next START is accepted at E9 or later.
- START while BUSY=1 is ignored; DATA1/DATA2 changes during BUSY have no effect.
- PRODUCT changes only at the final CALC edge or on reset, never mid-calculation.
- Operands of 0 still take the full WIDTH iterations; there is no early exit.
- Carry is derived locally because the Add unit has no carry output. It is required for correct results once the partial sum exceeds 255.

Test Plan:
- Reset with RESET_N=0 mid-CLK -> all outputs 0 immediately. Release, START with 25*3 -> DONE 9 cycles after the START edge, PRODUCT=16'h004B (75).
- 255*255 -> PRODUCT=16'hFE01; the carry path is exercised on every iteration.
- 16*16 -> PRODUCT=16'h0100. Then 200*200 -> 16'h9C40, with no residue from the previous result.
- 0*173 and 173*0 -> PRODUCT=0, still 8 CALC cycles, DONE pulse width exactly 1.
- START held high throughout with DATA1 changed mid-CALC -> first result uses the captured operands. The next operation starts only at the IDLE edge after DONE.
- RESET_N asserted at CALC iteration 4 of 7*9 -> state IDLE, PRODUCT=0, no DONE. A new 7*9 after release gives 16'h003F.
